// File: rtl/rr_dmux4_arbiter.sv
// Round-robin arbiter for a shared 4-way demultiplexed write path.
// Emits a registered one-hot grant plus the 2-bit demux select code.
// Supports multi-cycle ownership, zero-gap handoff, and a bounded hold
// timeout that forces a one-cycle release when others are waiting.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; next nonzero req is granted on the coming edge
// OWN     | sel holds the owner; grant one-hot, hold counter running
// PREEMPT | owner revoked by timeout; one dead cycle, then acts as IDLE
module rr_dmux4_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic       busy,
    output logic       preempt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        PREEMPT = 2'd2
    } state_t;

    // Counter value at which the owner has held the grant HOLD_MAX cycles.
    localparam int HOLD_LAST = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;

    state_t           state_q, state_n;
    logic [3:0]       grant_q, grant_n;
    logic [1:0]       sel_q, sel_n;
    logic             busy_q, busy_n;
    logic             preempt_q, preempt_n;
    logic [1:0]       last_q, last_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;

    logic [1:0]       win;
    logic [3:0]       others;

    // Search last+1, last+2, last+3, last; first set request wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // In OWN, last_q equals the owner, so one picker serves both the
    // fresh-grant and the handoff case.
    assign win    = rr_pick(req, last_q);
    assign others = req & ~(4'b0001 << sel_q);

    // Next-state and next-output decode.
    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        sel_n     = sel_q;
        busy_n    = busy_q;
        preempt_n = 1'b0;
        last_n    = last_q;
        cnt_n     = cnt_q;
        case (state_q)
            IDLE, PREEMPT: begin
                if (|req) begin
                    state_n = OWN;
                    grant_n = 4'b0001 << win;
                    sel_n   = win;
                    busy_n  = 1'b1;
                    last_n  = win;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                    grant_n = 4'b0000;
                    busy_n  = 1'b0;
                end
            end
            OWN: begin
                if (req[sel_q]) begin
                    // >= also covers a counter that ran past the limit while
                    // the owner was alone and a competitor shows up later.
                    if ((HOLD_MAX != 0) && (|others) && (cnt_q >= CNT_W'(HOLD_LAST))) begin
                        state_n   = PREEMPT;
                        grant_n   = 4'b0000;
                        busy_n    = 1'b0;
                        preempt_n = 1'b1;
                        last_n    = sel_q;
                    end else if (cnt_q != '1) begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end else if (|others) begin
                    grant_n = 4'b0001 << win;
                    sel_n   = win;
                    last_n  = win;
                    cnt_n   = '0;
                end else begin
                    state_n = IDLE;
                    grant_n = 4'b0000;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = 4'b0000;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= 4'b0000;
            sel_q     <= 2'b00;
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            last_q    <= 2'd3;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            sel_q     <= sel_n;
            busy_q    <= busy_n;
            preempt_q <= preempt_n;
            last_q    <= last_n;
            cnt_q     <= cnt_n;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign preempt = preempt_q;

endmodule
